// File: rtl/rule90_row_checker_pkg.sv
// Shared definitions for the rule-90 row generator and checker: FSM state
// encoding and the reference next-row function.
package rule90_row_checker_pkg;

    localparam int ROW_W = 8;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Each bit becomes the XOR of its two neighbours; bits shifted in are zero.
    function automatic logic [ROW_W-1:0] rule90_next(input logic [ROW_W-1:0] cur);
        return (cur << 1) ^ (cur >> 1);
    endfunction

endpackage

// File: rtl/rule90_row_checker_step.sv
// Combinational rule-90 step: next[i] = cur[i-1] ^ cur[i+1], out-of-range
// neighbours read as zero.
module rule90_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] next
);

    logic [WIDTH+1:0] padded;

    assign padded = {1'b0, cur, 1'b0};

    // padded[gi] is cur[gi-1] and padded[gi+2] is cur[gi+1].
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign next[gi] = padded[gi] ^ padded[gi+2];
    end

endmodule

// File: rtl/rule90_row_checker.sv
// Receive-side checker for a rule-90 row stream: acquires lock on a run of
// consistent rows, then flywheels its own prediction and counts errors.
module rule90_row_checker
    import rule90_row_checker_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int LOCK_COUNT  = 4,
    parameter int LOSS_THRESH = 3,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] row_in,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             lock_pulse,
    output logic             loss_pulse,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(LOSS_THRESH + 1);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   last_row_reg, last_row_next;
    logic [GOOD_W-1:0]  good_reg, good_next;
    logic [BAD_W-1:0]   bad_reg, bad_next;
    logic [ERR_W-1:0]   err_reg, err_next;
    logic               mismatch_reg, mismatch_next;
    logic               lock_pulse_reg, lock_pulse_next;
    logic               loss_pulse_reg, loss_pulse_next;

    logic [WIDTH-1:0]   pred;
    logic               sample;
    logic               row_match;
    logic               row_zero;

    rule90_step #(.WIDTH(WIDTH)) u_step (
        .cur  (last_row_reg),
        .next (pred)
    );

    assign sample    = ena & in_valid;
    assign row_match = (row_in == pred);
    assign row_zero  = (row_in == '0);

    always_comb begin
        state_next      = state_reg;
        last_row_next   = last_row_reg;
        good_next       = good_reg;
        bad_next        = bad_reg;
        err_next        = err_reg;
        mismatch_next   = mismatch_reg;
        lock_pulse_next = 1'b0;
        loss_pulse_next = 1'b0;

        if (sample) begin
            case (state_reg)
                SEARCH: begin
                    if (!row_zero) begin
                        last_row_next = row_in;
                        good_next     = '0;
                        state_next    = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    last_row_next = row_in;
                    if (row_match) begin
                        if (good_reg == GOOD_W'(LOCK_COUNT - 1)) begin
                            good_next       = '0;
                            bad_next        = '0;
                            mismatch_next   = 1'b0;
                            lock_pulse_next = 1'b1;
                            state_next      = LOCKED;
                        end else begin
                            good_next = good_reg + GOOD_W'(1);
                        end
                    end else begin
                        good_next = '0;
                        if (row_zero) begin
                            state_next = SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel on the prediction so one bad row is one error.
                    last_row_next = pred;
                    if (row_match) begin
                        mismatch_next = 1'b0;
                        bad_next      = '0;
                    end else begin
                        mismatch_next = 1'b1;
                        if (err_reg != '1) begin
                            err_next = err_reg + ERR_W'(1);
                        end
                        if (bad_reg == BAD_W'(LOSS_THRESH - 1)) begin
                            last_row_next   = row_in;
                            good_next       = '0;
                            bad_next        = '0;
                            mismatch_next   = 1'b0;
                            loss_pulse_next = 1'b1;
                            state_next      = ACQUIRE;
                        end else begin
                            bad_next = bad_reg + BAD_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = SEARCH;
                end
            endcase
        end

        // Clear wins over a same-cycle error increment.
        if (ena && clear_cnt) begin
            err_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= SEARCH;
            last_row_reg   <= '0;
            good_reg       <= '0;
            bad_reg        <= '0;
            err_reg        <= '0;
            mismatch_reg   <= 1'b0;
            lock_pulse_reg <= 1'b0;
            loss_pulse_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_row_reg   <= last_row_next;
            good_reg       <= good_next;
            bad_reg        <= bad_next;
            err_reg        <= err_next;
            mismatch_reg   <= mismatch_next;
            lock_pulse_reg <= lock_pulse_next;
            loss_pulse_reg <= loss_pulse_next;
        end
    end

    assign locked     = (state_reg == LOCKED);
    assign lock_pulse = lock_pulse_reg;
    assign loss_pulse = loss_pulse_reg;
    assign mismatch   = mismatch_reg;
    assign err_cnt    = err_reg;

endmodule

// File: tb/tb_rule90_row_checker.sv
// Directed self-checking bench for rule90_row_checker: lock, single error,
// loss/relock, zero stream, saturation/clear, freeze and async reset.
module tb_rule90_row_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] row_in = 8'h00;
    logic       clear_cnt = 1'b0;
    logic       locked;
    logic       lock_pulse;
    logic       loss_pulse;
    logic       mismatch;
    logic [7:0] err_cnt;

    int vectors = 0;
    int miscompares = 0;

    rule90_row_checker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_valid   (in_valid),
        .row_in     (row_in),
        .clear_cnt  (clear_cnt),
        .locked     (locked),
        .lock_pulse (lock_pulse),
        .loss_pulse (loss_pulse),
        .mismatch   (mismatch),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] r90(input logic [7:0] c);
        logic [7:0] n;
        for (int i = 0; i < 8; i++) begin
            n[i] = ((i > 0) ? c[i-1] : 1'b0) ^ ((i < 7) ? c[i+1] : 1'b0);
        end
        return n;
    endfunction

    function automatic logic [7:0] bad_of(input logic [7:0] p);
        return (p == 8'hFF) ? 8'h01 : ~p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] r, input logic clr);
        @(negedge clk);
        row_in    = r;
        in_valid  = 1'b1;
        clear_cnt = clr;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clear_cnt = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] cur;
        logic [7:0] b;

        // Reset state
        #12;
        chk("reset_locked", locked, 0);
        chk("reset_err", err_cnt, 0);
        chk("reset_mismatch", mismatch, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero stream never leaves SEARCH
        for (int i = 0; i < 6; i++) send(8'h00, 1'b0);
        chk("zero_locked", locked, 0);
        send(8'h28, 1'b0);
        chk("zero_then_seed_locked", locked, 0);

        // Clean stream acquisition
        send(8'h10, 1'b0);
        send(8'h28, 1'b0);
        send(8'h44, 1'b0);
        send(8'hAA, 1'b0);
        chk("pre_lock_locked", locked, 0);
        send(8'h01, 1'b0);
        chk("clean_locked", locked, 1);
        chk("clean_lock_pulse", lock_pulse, 1);
        chk("clean_err", err_cnt, 0);
        idle();
        chk("lock_pulse_one_cycle", lock_pulse, 0);
        chk("locked_held", locked, 1);

        // Single corrupted row (0x02 expected)
        send(8'h03, 1'b0);
        chk("single_mismatch", mismatch, 1);
        chk("single_err", err_cnt, 1);
        chk("single_locked", locked, 1);
        idle();
        chk("mismatch_held", mismatch, 1);
        send(8'h05, 1'b0);
        chk("single_recover_mismatch", mismatch, 0);
        chk("single_recover_err", err_cnt, 1);
        send(8'h08, 1'b0);
        chk("single_still_locked", locked, 1);

        // Clear with no sample
        @(negedge clk);
        clear_cnt = 1'b1;
        @(posedge clk);
        #1;
        clear_cnt = 1'b0;
        chk("clear_idle_err", err_cnt, 0);

        // Loss: three 0xFF rows while expecting 0x14, 0x22, 0x55
        send(8'hFF, 1'b0);
        chk("loss1_err", err_cnt, 1);
        send(8'hFF, 1'b0);
        chk("loss2_locked", locked, 1);
        send(8'hFF, 1'b0);
        chk("loss3_err", err_cnt, 3);
        chk("loss3_pulse", loss_pulse, 1);
        chk("loss3_locked", locked, 0);
        chk("loss3_mismatch", mismatch, 0);
        idle();
        chk("loss_pulse_one_cycle", loss_pulse, 0);

        // Relock from reseed 0xFF
        send(8'h81, 1'b0);
        send(8'h42, 1'b0);
        send(8'hA5, 1'b0);
        chk("relock_pre", locked, 0);
        send(8'h18, 1'b0);
        chk("relock_locked", locked, 1);
        chk("relock_pulse", lock_pulse, 1);
        chk("relock_err_kept", err_cnt, 3);

        // Saturation: alternate good/bad so lock holds
        cur = 8'h18;
        for (int i = 0; i < 300; i++) begin
            cur = r90(cur);
            send(cur, 1'b0);
            cur = r90(cur);
            send(bad_of(cur), 1'b0);
            if (i == 251) chk("sat_at_255", err_cnt, 255);
        end
        chk("sat_err", err_cnt, 8'hFF);
        chk("sat_locked", locked, 1);

        // Clear with a same-cycle error
        cur = r90(cur);
        send(bad_of(cur), 1'b1);
        chk("clear_same_cycle_err", err_cnt, 0);
        chk("clear_same_cycle_mismatch", mismatch, 1);
        cur = r90(cur);
        send(cur, 1'b0);
        chk("post_clear_mismatch", mismatch, 0);

        // Freeze while locked: bad rows ignored
        ena = 1'b0;
        send(bad_of(r90(cur)), 1'b0);
        send(bad_of(r90(cur)), 1'b0);
        chk("freeze_locked_err", err_cnt, 0);
        chk("freeze_locked_mismatch", mismatch, 0);
        ena = 1'b1;

        // Drop lock, then freeze in ACQUIRE
        for (int i = 0; i < 3; i++) begin
            cur = r90(cur);
            b = bad_of(cur);
            send(b, 1'b0);
        end
        chk("drop_locked", locked, 0);
        chk("drop_err", err_cnt, 3);
        cur = b;
        ena = 1'b0;
        b = cur;
        for (int i = 0; i < 5; i++) begin
            b = r90(b);
            send(b, 1'b0);
        end
        chk("freeze_acq_locked", locked, 0);
        chk("freeze_acq_err", err_cnt, 3);
        ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cur = r90(cur);
            send(cur, 1'b0);
        end
        chk("unfreeze_relock", locked, 1);

        // Async reset mid-ACQUIRE
        for (int i = 0; i < 3; i++) begin
            cur = r90(cur);
            send(bad_of(cur), 1'b0);
        end
        send(r90(bad_of(cur)), 1'b0);
        chk("pre_reset_err", err_cnt, 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_err", err_cnt, 0);
        chk("async_reset_locked", locked, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // No partial lock survives: seed plus 3 matches is not enough
        send(8'h10, 1'b0);
        send(8'h28, 1'b0);
        send(8'h44, 1'b0);
        send(8'hAA, 1'b0);
        chk("post_reset_no_lock", locked, 0);
        send(8'h01, 1'b0);
        chk("post_reset_lock", locked, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
